// File: rtl/uart_baud_gen_pkg.sv
// Shared UART constants: fractional divisor width, oversample-counter width
// helper and default divisors for the supported baud rates at 50 MHz.
package uart_baud_gen_pkg;

  localparam int FRAC_W = 4;
  localparam int CLK_HZ = 50_000_000;

  // Divisors are expressed per oversample period (16x): integer + sixteenths.
  localparam int DIV_INT_115200  = 27;
  localparam int DIV_FRAC_115200 = 2;
  localparam int DIV_INT_9600    = 325;
  localparam int DIV_FRAC_9600   = 8;

  // Priority-resolved per-cycle action of the generator.
  typedef enum logic [1:0] {
    CMD_HOLD    = 2'd0,
    CMD_RUN     = 2'd1,
    CMD_RESTART = 2'd2,
    CMD_LOAD    = 2'd3
  } baud_cmd_e;

  function automatic int os_w(input int oversample);
    return $clog2(oversample);
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac.sv
// Fractional divisor accumulator: adds div_frac once per sample period and
// emits a carry that stretches the following period by one cycle.
module uart_frac_accum
  import uart_baud_gen_pkg::*;
(
  input  logic              sysclk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  input  logic [FRAC_W-1:0] frac_in,
  output logic [FRAC_W-1:0] frac_acc,
  output logic              carry
);

  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic              carry_q, carry_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    frac_acc_d = frac_acc_q;
    carry_d    = carry_q;
    sum        = {1'b0, frac_acc_q} + {1'b0, frac_in};
    if (clr) begin
      frac_acc_d = '0;
      carry_d    = 1'b0;
    end else if (adv) begin
      {carry_d, frac_acc_d} = sum;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      frac_acc_q <= '0;
      carry_q    <= 1'b0;
    end else begin
      frac_acc_q <= frac_acc_d;
      carry_q    <= carry_d;
    end
  end

  assign frac_acc = frac_acc_q;
  assign carry    = carry_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: fractional-N oversample strobe, bit strobe and a
// 50%-duty bit clock, with run-time divisor load and RX phase resync.
module uart_baud_gen
  import uart_baud_gen_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_DIV  = 27,
  parameter int DEFAULT_FRAC = 2
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              resync,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_int_in,
  input  logic [FRAC_W-1:0] div_frac_in,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic              baud_clk
);

  localparam int               OS_W    = os_w(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0]  div_int_q, div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic              sample_tick_q, sample_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              baud_clk_q, baud_clk_d;

  baud_cmd_e         cmd;
  logic [DIV_W:0]    period_m1;
  logic              wrap;
  logic              carry;
  logic [FRAC_W-1:0] frac_acc;
  logic [DIV_W-1:0]  div_int_clamped;

  // A divisor load also restarts the phase, so it wins over resync.
  always_comb begin
    if (div_wr)      cmd = CMD_LOAD;
    else if (resync) cmd = CMD_RESTART;
    else if (enable) cmd = CMD_RUN;
    else             cmd = CMD_HOLD;
  end

  // Period is one cycle longer whenever the accumulator carried last wrap.
  always_comb begin
    period_m1 = {1'b0, div_int_q} + {{DIV_W{1'b0}}, carry} - {{DIV_W{1'b0}}, 1'b1};
    wrap      = (cmd == CMD_RUN) && ({1'b0, cnt_q} == period_m1);
    div_int_clamped = (div_int_in < MIN_DIV) ? MIN_DIV : div_int_in;
  end

  always_comb begin
    cnt_d         = cnt_q;
    os_cnt_d      = os_cnt_q;
    div_int_d     = div_int_q;
    div_frac_d    = div_frac_q;
    sample_tick_d = 1'b0;
    bit_tick_d    = 1'b0;
    baud_clk_d    = baud_clk_q;
    unique case (cmd)
      CMD_LOAD: begin
        cnt_d      = '0;
        os_cnt_d   = '0;
        baud_clk_d = 1'b0;
        div_int_d  = div_int_clamped;
        div_frac_d = div_frac_in;
      end
      CMD_RESTART: begin
        cnt_d      = '0;
        os_cnt_d   = '0;
        baud_clk_d = 1'b0;
      end
      CMD_RUN: begin
        if (wrap) begin
          cnt_d         = '0;
          os_cnt_d      = os_cnt_q + OS_W'(1);
          sample_tick_d = 1'b1;
          bit_tick_d    = (os_cnt_q == OS_LAST);
          if ((os_cnt_q == OS_LAST) || (os_cnt_q == OS_HALF))
            baud_clk_d = ~baud_clk_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      CMD_HOLD: begin
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      os_cnt_q      <= '0;
      div_int_q     <= DIV_W'(DEFAULT_DIV);
      div_frac_q    <= FRAC_W'(DEFAULT_FRAC);
      sample_tick_q <= 1'b0;
      bit_tick_q    <= 1'b0;
      baud_clk_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      os_cnt_q      <= os_cnt_d;
      div_int_q     <= div_int_d;
      div_frac_q    <= div_frac_d;
      sample_tick_q <= sample_tick_d;
      bit_tick_q    <= bit_tick_d;
      baud_clk_q    <= baud_clk_d;
    end
  end

  uart_frac_accum u_frac (
    .sysclk   (sysclk),
    .reset    (reset),
    .clr      ((cmd == CMD_LOAD) || (cmd == CMD_RESTART)),
    .adv      (wrap),
    .frac_in  (div_frac_q),
    .frac_acc (frac_acc),
    .carry    (carry)
  );

  assign sample_tick = sample_tick_q;
  assign bit_tick    = bit_tick_q;
  assign baud_clk    = baud_clk_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: reset defaults, integer and fractional
// divisors, clamp, freeze, resync and asynchronous reset.
module tb_uart_baud_gen;

  logic        sysclk;
  logic        reset;
  logic        enable;
  logic        resync;
  logic        div_wr;
  logic [15:0] div_int_in;
  logic [3:0]  div_frac_in;
  logic        sample_tick;
  logic        bit_tick;
  logic        baud_clk;

  integer n_cmp = 0;
  integer n_err = 0;
  integer n, total, sum, bad, bits;

  localparam int S_SAMPLE  = 0;
  localparam int S_BIT     = 1;
  localparam int S_BAUD_HI = 2;
  localparam int S_BAUD_LO = 3;

  uart_baud_gen #(
    .DIV_W(16), .OVERSAMPLE(16), .DEFAULT_DIV(27), .DEFAULT_FRAC(2)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .enable      (enable),
    .resync      (resync),
    .div_wr      (div_wr),
    .div_int_in  (div_int_in),
    .div_frac_in (div_frac_in),
    .sample_tick (sample_tick),
    .bit_tick    (bit_tick),
    .baud_clk    (baud_clk)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input integer obs, input integer exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input int sel);
    case (sel)
      S_SAMPLE:  return sample_tick === 1'b1;
      S_BIT:     return bit_tick === 1'b1;
      S_BAUD_HI: return baud_clk === 1'b1;
      default:   return baud_clk === 1'b0;
    endcase
  endfunction

  // Counts negedges until the selected condition holds; -1 on timeout.
  task automatic wait_for(input int sel, input integer limit, output integer cyc);
    cyc = 0;
    do begin
      @(negedge sysclk);
      cyc = cyc + 1;
    end while (!hit(sel) && cyc < limit);
    if (!hit(sel)) cyc = -1;
  endtask

  task automatic load(input logic [15:0] di, input logic [3:0] df, input logic rs);
    div_wr      = 1'b1;
    resync      = rs;
    div_int_in  = di;
    div_frac_in = df;
    @(negedge sysclk);
    div_wr = 1'b0;
    resync = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; resync = 1'b0; div_wr = 1'b0;
    div_int_in = '0; div_frac_in = '0;

    // Reset state and default divisor 27 + 2/16
    repeat (3) @(negedge sysclk);
    check("rst_sample_tick", sample_tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_baud_clk", baud_clk, 0);
    reset = 1'b1;
    wait_for(S_SAMPLE, 100, n);
    check("default_first_tick", n, 27);
    total = n; sum = 0; bits = 0;
    for (int k = 2; k <= 17; k++) begin
      wait_for(S_SAMPLE, 100, n);
      total = total + n;
      sum = sum + n;
      bits = bits + (bit_tick ? 1 : 0);
      if (k == 7) check("default_baud_low_t7", baud_clk, 0);
      if (k == 8) check("default_baud_rise_t8", baud_clk, 1);
      if (k == 16) begin
        check("default_bit_t16", bit_tick, 1);
        check("default_t16_cycles", total, 433);
        check("default_baud_fall_t16", baud_clk, 0);
      end
    end
    check("default_bit_count", bits, 1);
    check("default_16_periods", sum, 434);

    // Integer divisor 4
    load(16'd4, 4'd0, 1'b0);
    check("int_load_tick_clear", sample_tick, 0);
    wait_for(S_SAMPLE, 100, n);
    check("int_first_tick", n, 4);
    bad = 0;
    for (int k = 2; k <= 16; k++) begin
      wait_for(S_SAMPLE, 100, n);
      if (n != 4) bad = bad + 1;
    end
    check("int_period_errors", bad, 0);
    check("int_bit_t16", bit_tick, 1);
    wait_for(S_BAUD_HI, 200, n);
    check("int_baud_low_run", n, 32);
    wait_for(S_BAUD_LO, 200, n);
    check("int_baud_high_run", n, 32);
    wait_for(S_BIT, 200, n);
    check("int_bit_period", n, 64);

    // Fractional divisor 10 + 8/16
    load(16'd10, 4'd8, 1'b0);
    wait_for(S_SAMPLE, 100, n);
    check("frac_first_tick", n, 10);
    sum = 0; bad = 0;
    for (int j = 1; j <= 32; j++) begin
      wait_for(S_SAMPLE, 100, n);
      sum = sum + n;
      if (n != ((j % 2 == 1) ? 10 : 11)) bad = bad + 1;
    end
    check("frac_alternation_errors", bad, 0);
    check("frac_32_periods", sum, 336);

    // Clamp to 2, then freeze on a tick
    load(16'd0, 4'd0, 1'b0);
    wait_for(S_SAMPLE, 100, n);
    check("clamp_first_tick", n, 2);
    wait_for(S_SAMPLE, 100, n);
    check("clamp_second_tick", n, 2);
    for (int k = 3; k <= 8; k++) wait_for(S_SAMPLE, 100, n);
    check("clamp_baud_rise_t8", baud_clk, 1);
    enable = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge sysclk);
      if (sample_tick !== 1'b0 || bit_tick !== 1'b0 || baud_clk !== 1'b1) bad = bad + 1;
    end
    check("freeze_errors", bad, 0);
    enable = 1'b1;
    wait_for(S_SAMPLE, 100, n);
    check("freeze_resume_phase", n, 2);
    check("freeze_baud_held", baud_clk, 1);

    // Resync on the tick with os_cnt = 9
    load(16'd4, 4'd0, 1'b0);
    for (int k = 1; k <= 9; k++) wait_for(S_SAMPLE, 100, n);
    check("resync_pre_baud", baud_clk, 1);
    resync = 1'b1;
    @(negedge sysclk);
    resync = 1'b0;
    check("resync_sample_clear", sample_tick, 0);
    check("resync_baud_clear", baud_clk, 0);
    wait_for(S_BIT, 200, n);
    check("resync_bit_latency", n, 64);

    // div_wr together with resync loads 20, then async reset at cnt=13
    load(16'd20, 4'd0, 1'b1);
    wait_for(S_BAUD_HI, 400, n);
    check("load_resync_baud_rise", n, 160);
    repeat (13) @(negedge sysclk);
    check("areset_pre_baud", baud_clk, 1);
    #2 reset = 1'b0;
    #1;
    check("areset_sample", sample_tick, 0);
    check("areset_bit", bit_tick, 0);
    check("areset_baud", baud_clk, 0);
    @(negedge sysclk);
    reset = 1'b1;
    wait_for(S_SAMPLE, 100, n);
    check("areset_div_restored", n, 27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised UART baud-rate generator that produces an oversampling strobe, a bit-rate strobe and a 50%-duty bit-rate clock from the system clock. The divisor has an integer and a 4-bit fractional part, is programmable at run time, and the phase can be re-aligned on a receive start edge. It sits between the CPU peripheral bus, which writes the divisor, and the UART TX/RX engines, which consume the strobes.

## Interface
- DIV_W, 16, width of the integer divisor field
- OVERSAMPLE, 16, sample strobes per bit; power of two, at least 4
- DEFAULT_DIV, 27, integer divisor loaded at reset (50 MHz / (16 × 115200) ≈ 27.13)
- DEFAULT_FRAC, 2, fractional divisor in sixteenths loaded at reset

- sysclk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  count enable; low freezes the generator
- resync  in  1  synchronous phase restart (RX start-bit alignment)
- div_wr  in  1  load strobe for div_int_in/div_frac_in
- div_int_in  in  DIV_W  new integer divisor
- div_frac_in  in  4  new fractional divisor, in units of 1/16
- sample_tick  out  1  one-cycle pulse at the oversample rate
- bit_tick  out  1  one-cycle pulse at the bit rate
- baud_clk  out  1  square wave at the bit rate, 50% duty in sample periods

## Operation
- State: cnt (DIV_W), os_cnt (log2 OVERSAMPLE), frac_acc (4), carry (1), div_int (DIV_W), div_frac (4), plus registered outputs.
- Reset values: cnt=0, os_cnt=0, frac_acc=0, carry=0, div_int=DEFAULT_DIV, div_frac=DEFAULT_FRAC, sample_tick=0, bit_tick=0, baud_clk=0.
- Period length is P = div_int + carry, so the average sample period is div_int + div_frac/16 cycles.
- The following applies on each edge where enable=1 and neither resync nor div_wr is active:
  - If cnt == P-1: cnt←0 and sample_tick←1. Also {carry, frac_acc} ← frac_acc + div_frac (5-bit sum), and os_cnt←os_cnt+1 (wraps modulo OVERSAMPLE).
  - Otherwise: cnt←cnt+1 and sample_tick←0.
  - bit_tick←1 only together with a sample_tick for which os_cnt was OVERSAMPLE-1.
  - baud_clk toggles together with a sample_tick for which os_cnt was OVERSAMPLE/2-1 or OVERSAMPLE-1.
- enable=0 freezes all counters. sample_tick and bit_tick go 0, and baud_clk holds its level.
- resync=1, regardless of enable: cnt, os_cnt, frac_acc and carry go to 0, both ticks go to 0, and baud_clk goes to 0.
- div_wr=1, regardless of enable:
  - Same restart as resync.
  - div_int←max(div_int_in, 2) and div_frac←div_frac_in. A minimum period of 2 guarantees that sample_tick deasserts between pulses.
- div_wr and resync asserted together behave as div_wr alone.
- Asserting reset mid-period immediately returns everything to the reset values, with no partial tick.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- After reset deassertion, or after resync/div_wr, with enable held high: the first sample_tick is high during the cycle after the P-th enabled edge, where P = div_int because carry=0.
- bit_tick period is the sum of OVERSAMPLE sample periods. With div_frac=0 that is exactly OVERSAMPLE×div_int cycles.
- baud_clk has a high phase of OVERSAMPLE/2 sample periods and a low phase of OVERSAMPLE/2 sample periods. The first rising edge coincides with the (OVERSAMPLE/2)-th sample_tick.
- Cycles with enable low are not counted. Phase resumes exactly where it stopped.
- The cnt wrap uses P from the current carry. carry updates on the same edge, so the new P applies to the next period.

## Structure
- Shared UART package: FRAC_W=4 and an OS_W=$clog2(OVERSAMPLE) helper function, plus default divisor constants for the supported baud rates (9600, 115200 at 50 MHz).
- Natural sub-module: uart_frac_accum, which holds frac_acc and carry and updates on sample_tick. The top level holds the counters, the divisor registers and the output flops.

## Test plan
- Reset and default: hold reset low for 3 cycles, then release with enable=1 and DEFAULT_DIV=27/FRAC=2. Required: first sample_tick 27 cycles later. Over 16 sample ticks: period sum 434 cycles (14×27 + 2×28), one bit_tick on the 16th, baud_clk rising at the 8th tick.
- Integer divisor: div_wr with int=4, frac=0, then 64 enabled cycles. Required: sample_tick every 4 cycles, bit_tick every 64 cycles, baud_clk 32 cycles high and 32 low.
- Fractional: div_wr with int=10, frac=8. Required: periods alternate 10, 11, 10, 11, …, averaging 10.5 over 32 ticks (336 cycles).
- Clamp and freeze: div_wr with int=0. Required: period 2. Then drop enable for 5 cycles mid-period. Required: no ticks, baud_clk held, and the same phase on resume.
- Resync: assert resync on the cycle of a sample_tick with os_cnt=9. Required: ticks and baud_clk go 0 next cycle, and the next bit_tick arrives 16×div_int cycles later.
- Async reset: assert reset mid-period at cnt=13 between clock edges. Required: all outputs go 0 immediately and div_int returns to 27.
